dir_escritura_seq: RTL and testbench

- Parametrised write-address sequencer for the RTC register bank.
- Walks a contiguous register window starting at BASE_ADDR (default 0x21..0x28), honouring a per-register enable mask; also supports a single-register mode selected by a 1-based index.
- For each selected register it presents the address and handshakes with the downstream bus-write controller (wr_req/wr_ack).
- Replaces the fixed combinational index-to-address decode. Tri-state drive is no longer done here: the top level gates the bus with addr_oe.

---
 rtl/dir_escritura_pkg.sv | 19 +
 rtl/dir_idx_map.sv | 21 ++
 rtl/dir_escritura_seq.sv | 136 +++++++++++++
 tb/tb_dir_escritura_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dir_escritura_pkg.sv
// Shared definitions for the RTC write-address sequencer: state encoding,
// default register window and the legal-index rule for single-register mode.
package dir_escritura_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [7:0] RTC_WR_BASE = 8'h21;
    localparam int         RTC_WR_NUM  = 8;

    // A 1-based register index is legal when it falls inside 1..num.
    function automatic logic idx_legal(input int idx, input int num);
        return (idx >= 1) && (idx <= num);
    endfunction

endpackage

// File: rtl/dir_idx_map.sv
// Index-to-address map for the write window, plus the illegal-index flag
// used to reject a single-mode request before any bus activity.
module dir_idx_map
    import dir_escritura_pkg::*;
#(
    parameter int              ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = RTC_WR_BASE,
    parameter int              NUM_REGS  = RTC_WR_NUM,
    parameter int              IDX_W     = 4
) (
    input  logic [IDX_W-1:0]  idx,
    input  logic [IDX_W-1:0]  sel_idx,
    output logic [ADDR_W-1:0] addr,
    output logic              sel_illegal
);

    // idx is 0-based here; wrap-around is modulo 2^ADDR_W.
    assign addr        = BASE_ADDR + ADDR_W'(idx);
    assign sel_illegal = !idx_legal(int'(sel_idx), NUM_REGS);

endmodule

// File: rtl/dir_escritura_seq.sv
// Write-address sequencer: sweeps the RTC register window under a per-register
// mask, or writes one selected register, handshaking each write with wr_req/wr_ack.
module dir_escritura_seq
    import dir_escritura_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = RTC_WR_BASE,
    parameter int                NUM_REGS  = RTC_WR_NUM,
    parameter int                IDX_W     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                EN,
    input  logic                start,
    input  logic                single,
    input  logic [IDX_W-1:0]    sel_idx,
    input  logic [NUM_REGS-1:0] mask,
    input  logic                wr_ack,
    output logic [ADDR_W-1:0]   addr_out,
    output logic                addr_oe,
    output logic                wr_req,
    output logic [IDX_W-1:0]    idx_out,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                abort,
    output logic [2:0]          state_dbg
);

    localparam int               MASK_W   = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    generate
        if (int'(BASE_ADDR) + NUM_REGS - 1 >= (1 << ADDR_W)) begin : g_bad_window
            $error("dir_escritura_seq: register window exceeds address space");
        end
        if ((1 << IDX_W) <= NUM_REGS) begin : g_bad_idx_w
            $error("dir_escritura_seq: IDX_W too narrow for NUM_REGS");
        end
    endgenerate

    logic [2:0]          state;
    logic [IDX_W-1:0]    idx;
    logic                single_q;
    logic [NUM_REGS-1:0] mask_q;
    logic [MASK_W-1:0]   mask_ext;
    logic [ADDR_W-1:0]   map_addr;
    logic                sel_illegal;

    dir_idx_map #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W)
    ) u_map (
        .idx         (idx),
        .sel_idx     (sel_idx),
        .addr        (map_addr),
        .sel_illegal (sel_illegal)
    );

    // Widened so the mask can be indexed directly by the idx counter.
    assign mask_ext = MASK_W'(mask_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            single_q <= 1'b0;
            mask_q   <= '0;
            addr_out <= '0;
            idx_out  <= '0;
            err      <= 1'b0;
            abort    <= 1'b0;
        end else begin
            err   <= 1'b0;
            abort <= 1'b0;
            if (state == S_IDLE) begin
                if (start && EN) begin
                    if (!single) begin
                        idx      <= '0;
                        single_q <= 1'b0;
                        mask_q   <= mask;
                        state    <= S_CHECK;
                    end else if (!sel_illegal) begin
                        idx      <= sel_idx - ONE;
                        single_q <= 1'b1;
                        mask_q   <= mask;
                        state    <= S_CHECK;
                    end else begin
                        err <= 1'b1;
                    end
                end
            end else if (!EN) begin
                // Abort beats a coincident wr_ack: the write is abandoned.
                state   <= S_IDLE;
                idx_out <= '0;
                abort   <= 1'b1;
            end else begin
                case (state)
                    S_CHECK: begin
                        addr_out <= map_addr;
                        idx_out  <= idx + ONE;
                        if (!single_q && !mask_ext[idx]) state <= S_NEXT;
                        else                             state <= S_REQ;
                    end
                    S_REQ: begin
                        if (wr_ack) state <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (single_q || idx == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + ONE;
                            state <= S_CHECK;
                        end
                    end
                    S_DONE: begin
                        idx_out <= '0;
                        state   <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Handshake and status outputs are pure decodes of the state register.
    assign wr_req    = (state == S_REQ);
    assign addr_oe   = (state == S_REQ);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_dir_escritura_seq.sv
// Bench for dir_escritura_seq: a reference model queues the expected bus events
// per start request; a monitor pops and compares each event the DUT presents.
module tb_dir_escritura_seq;

  localparam int         NUM_REGS = 8;
  localparam int         IDX_W    = 4;
  localparam logic [7:0] BASE     = 8'h21;
  localparam logic [1:0] EV_REQ   = 2'd0;
  localparam logic [1:0] EV_DONE  = 2'd1;
  localparam logic [1:0] EV_ERR   = 2'd2;
  localparam logic [1:0] EV_ABORT = 2'd3;

  logic                clk;
  logic                reset;
  logic                en;
  logic                start;
  logic                single;
  logic [IDX_W-1:0]    sel_idx;
  logic [NUM_REGS-1:0] mask;
  logic                wr_ack;
  logic [7:0]          addr_out;
  logic                addr_oe;
  logic                wr_req;
  logic [IDX_W-1:0]    idx_out;
  logic                busy;
  logic                done;
  logic                err;
  logic                abort;
  logic [2:0]          state_dbg;

  logic [13:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int ack_min = 0;
  int ack_max = 0;
  int ack_limit = -1;
  int acks_given = 0;
  logic prev_req = 1'b0;

  dir_escritura_seq dut (
    .clk       (clk),
    .reset     (reset),
    .EN        (en),
    .start     (start),
    .single    (single),
    .sel_idx   (sel_idx),
    .mask      (mask),
    .wr_ack    (wr_ack),
    .addr_out  (addr_out),
    .addr_oe   (addr_oe),
    .wr_req    (wr_req),
    .idx_out   (idx_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .abort     (abort),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: expected event list for one start request
  task automatic push_req(input int i);
    exp_q.push_back({EV_REQ, 4'(i), BASE + 8'(i - 1)});
  endtask

  task automatic model_start(input logic sgl, input int sel, input logic [NUM_REGS-1:0] m);
    if (sgl) begin
      if (sel >= 1 && sel <= NUM_REGS) begin
        push_req(sel);
        exp_q.push_back({EV_DONE, 12'h0});
      end else begin
        exp_q.push_back({EV_ERR, 12'h0});
      end
    end else begin
      for (int i = 1; i <= NUM_REGS; i++)
        if (m[i-1]) push_req(i);
      exp_q.push_back({EV_DONE, 12'h0});
    end
  endtask

  // scoreboard monitor
  task automatic observe(input logic [13:0] ev);
    logic [13:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got %0h expected none", ev);
    end else begin
      e = exp_q.pop_front();
      check("event", 32'(ev), 32'(e));
    end
  endtask

  always @(negedge clk) begin
    if (wr_req && !prev_req) observe({EV_REQ, idx_out, addr_out});
    if (done)  observe({EV_DONE, 12'h0});
    if (err)   observe({EV_ERR, 12'h0});
    if (abort) observe({EV_ABORT, 12'h0});
    if (wr_req || addr_oe) check("oe_matches_req", 32'(addr_oe), 32'(wr_req));
    prev_req = wr_req;
  end

  // downstream bus controller: acknowledges each request after a random delay
  initial begin
    wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_req && (ack_limit < 0 || acks_given < ack_limit)) begin
        repeat ($urandom_range(ack_max, ack_min)) @(negedge clk);
        wr_ack = 1'b1;
        acks_given++;
        @(negedge clk);
        wr_ack = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic do_start(input logic sgl, input int sel, input logic [NUM_REGS-1:0] m);
    @(negedge clk);
    single  = sgl;
    sel_idx = IDX_W'(sel);
    mask    = m;
    start   = 1'b1;
    model_start(sgl, sel, m);
    @(negedge clk);
    start   = 1'b0;
    single  = 1'($urandom);
    sel_idx = IDX_W'($urandom);
    mask    = NUM_REGS'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("idle_timeout", 32'(busy), 32'(0));
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    int c;
    logic sgl;
    reset = 1'b0; en = 1'b1; start = 1'b0; single = 1'b0; sel_idx = '0; mask = '0;
    repeat (3) @(negedge clk);
    check("rst_addr_out", 32'(addr_out), 32'(0));
    check("rst_idx_out", 32'(idx_out), 32'(0));
    check("rst_wr_req", 32'(wr_req), 32'(0));
    check("rst_addr_oe", 32'(addr_oe), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_abort", 32'(abort), 32'(0));
    reset = 1'b1;
    @(negedge clk);

    // full sweep, ack three cycles after each request
    ack_min = 3; ack_max = 3;
    do_start(1'b0, 0, 8'hFF);
    @(negedge clk);
    check("first_req_latency", {23'h0, wr_req, addr_out}, {23'h0, 1'b1, 8'h21});
    wait_idle(300);

    // masked sweep
    ack_min = 0; ack_max = 2;
    do_start(1'b0, 0, 8'hA5);
    wait_idle(300);

    // single register
    do_start(1'b1, 5, NUM_REGS'($urandom));
    wait_idle(100);

    // illegal single-mode indices
    do_start(1'b1, 0, 8'hFF);
    check("err_idx0", 32'(err), 32'(1));
    check("err_idx0_busy", 32'(busy), 32'(0));
    wait_idle(10);
    do_start(1'b1, 9, 8'hFF);
    check("err_idx9", 32'(err), 32'(1));
    check("err_idx9_busy", 32'(busy), 32'(0));
    wait_idle(10);

    // start with EN low and stray ack while idle are both ignored
    @(negedge clk);
    en = 1'b0; start = 1'b1; single = 1'b0; mask = 8'hFF;
    @(negedge clk);
    start = 1'b0; en = 1'b1;
    check("start_en_low_busy", 32'(busy), 32'(0));
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    check("stray_ack_busy", 32'(busy), 32'(0));

    // EN dropped while waiting in REQ at 0x23
    acks_given = 0; ack_limit = 2;
    do_start(1'b0, 0, 8'hFF);
    exp_q.delete();
    push_req(1); push_req(2); push_req(3);
    exp_q.push_back({EV_ABORT, 12'h0});
    c = 0;
    while (!(wr_req && addr_out == 8'h23) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("reached_req_23", {23'h0, wr_req, addr_out}, {23'h0, 1'b1, 8'h23});
    en = 1'b0;
    @(negedge clk);
    check("abort_pulse", 32'(abort), 32'(1));
    check("abort_wr_req", 32'(wr_req), 32'(0));
    check("abort_addr_oe", 32'(addr_oe), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_no_done", 32'(done), 32'(0));
    en = 1'b1; ack_limit = -1;
    wait_idle(10);

    // asynchronous reset mid-sweep
    ack_min = 0; ack_max = 3;
    do_start(1'b0, 0, 8'hFF);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_rst_addr", 32'(addr_out), 32'(0));
    check("async_rst_idx", 32'(idx_out), 32'(0));
    check("async_rst_req", 32'(wr_req), 32'(0));
    check("async_rst_busy", 32'(busy), 32'(0));
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    do_start(1'b0, 0, NUM_REGS'($urandom) | 8'h01);
    @(negedge clk);
    check("restart_first_addr", {23'h0, wr_req, addr_out}, {23'h0, 1'b1, 8'h21});
    wait_idle(300);

    // randomized mix
    for (int t = 0; t < 20; t++) begin
      sgl = ($urandom_range(0, 2) == 0);
      do_start(sgl, $urandom_range(0, 10), NUM_REGS'($urandom));
      wait_idle(300);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
